// File: rtl/ring_token_ctrl_pkg.sv
// Shared types and constants for the ring token sequencer.
// Default ring geometry, sequencer states and the token-count legality rule.
package ring_token_ctrl_pkg;

  localparam int DEF_NSTAGE = 8;
  localparam int MAXTOK     = DEF_NSTAGE - 1;
  localparam int INFW       = $clog2(DEF_NSTAGE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INJECT,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } state_e;

  // A ring of n stages can hold at most n-1 tokens and needs at least one.
  function automatic logic tokens_legal(input int unsigned tok, input int unsigned maxtok);
    return (tok != 0) && (tok <= maxtok);
  endfunction

endpackage

// File: rtl/ring_token_ctrl_sync.sv
// Multi-flop synchronizer for one asynchronous ring-side level.
// The chain clears with the ring so both sides restart at phase 0.
module ring_sync #(
  parameter int SYNC = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC-1:0] chain_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC-2:0], d_i};
    end
  end

  assign q_o = chain_q[SYNC-1];

endmodule

// File: rtl/ring_token_ctrl.sv
// Sequencer that closes a self-timed ring, injects tokens, relays and counts
// returns, then drains; a watchdog aborts when the ring stops handshaking.
module ring_token_ctrl
  import ring_token_ctrl_pkg::*;
#(
  parameter int NSTAGE = DEF_NSTAGE,
  parameter int CNTW   = 16,
  parameter int TMOW   = 12,
  parameter int SYNC   = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic [$clog2(NSTAGE)-1:0] tokens_i,
  input  logic [CNTW-1:0]           ret_limit_i,
  output logic                      tx_req_o,
  input  logic                      tx_ack_i,
  input  logic                      rx_req_i,
  output logic                      rx_ack_o,
  output logic                      ring_en_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [CNTW-1:0]           ret_cnt_o
);

  localparam int TW = $clog2(NSTAGE);

  state_e          state_q, state_d;
  logic            tx_req_q, tx_req_d;
  logic            rx_ack_q, rx_ack_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] ret_cnt_q, ret_cnt_d;
  logic [TW-1:0]   inflight_q, inflight_d;
  logic [TW-1:0]   tok_q, tok_d;
  logic [CNTW-1:0] lim_q, lim_d;
  logic [TMOW-1:0] wdog_q, wdog_d;
  logic            ring_en_q, busy_q, done_q;
  logic            tx_ack_p_q, rx_req_p_q;

  logic tx_ack_s, rx_req_s;
  logic tx_pend, arrive, hs_evt, active, tok_ok;

  ring_sync #(.SYNC(SYNC)) u_sync_tx_ack (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (tx_ack_i),
    .q_o    (tx_ack_s)
  );

  ring_sync #(.SYNC(SYNC)) u_sync_rx_req (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_req_i),
    .q_o    (rx_req_s)
  );

  assign tx_pend = (tx_req_q != tx_ack_s);
  assign arrive  = (rx_req_s != rx_ack_q);
  assign hs_evt  = (tx_ack_s != tx_ack_p_q) || (rx_req_s != rx_req_p_q);
  assign active  = (state_q == ST_INJECT) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign tok_ok  = tokens_legal(32'(tokens_i), 32'(NSTAGE - 1));

  always_comb begin
    state_d    = state_q;
    tx_req_d   = tx_req_q;
    rx_ack_d   = rx_ack_q;
    err_d      = err_q;
    ret_cnt_d  = ret_cnt_q;
    inflight_d = inflight_q;
    tok_d      = tok_q;
    lim_d      = lim_q;
    wdog_d     = (active && !hs_evt) ? wdog_q + 1'b1 : '0;

    // Timeout abandons the run with the handshake phases left where they are.
    if (active && (wdog_q == '1)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      wdog_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (tok_ok) begin
              state_d    = ST_INJECT;
              ret_cnt_d  = '0;
              err_d      = 1'b0;
              inflight_d = '0;
              wdog_d     = '0;
              tok_d      = tokens_i;
              lim_d      = ret_limit_i;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_INJECT: begin
          if (stop_i) begin
            state_d = ST_DRAIN;
          end else if (!tx_pend) begin
            tx_req_d   = ~tx_req_q;
            inflight_d = inflight_q + 1'b1;
            if (inflight_d == tok_q) begin
              state_d = (lim_q == '0) ? ST_DRAIN : ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // A returning token is held until the first stage can take it again.
          if (arrive && !tx_pend) begin
            rx_ack_d  = ~rx_ack_q;
            tx_req_d  = ~tx_req_q;
            ret_cnt_d = (ret_cnt_q == '1) ? ret_cnt_q : ret_cnt_q + 1'b1;
          end
          if (stop_i || (ret_cnt_d >= lim_q)) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (arrive) begin
            rx_ack_d   = ~rx_ack_q;
            inflight_d = inflight_q - 1'b1;
          end
          if ((inflight_q == '0) && !tx_pend) begin
            state_d = ST_FIN;
          end
        end
        ST_FIN: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      tx_req_q   <= 1'b0;
      rx_ack_q   <= 1'b0;
      err_q      <= 1'b0;
      ret_cnt_q  <= '0;
      inflight_q <= '0;
      tok_q      <= '0;
      lim_q      <= '0;
      wdog_q     <= '0;
      ring_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_ack_p_q <= 1'b0;
      rx_req_p_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_req_q   <= tx_req_d;
      rx_ack_q   <= rx_ack_d;
      err_q      <= err_d;
      ret_cnt_q  <= ret_cnt_d;
      inflight_q <= inflight_d;
      tok_q      <= tok_d;
      lim_q      <= lim_d;
      wdog_q     <= wdog_d;
      ring_en_q  <= (state_d == ST_INJECT) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_FIN);
      tx_ack_p_q <= tx_ack_s;
      rx_req_p_q <= rx_req_s;
    end
  end

  assign tx_req_o  = tx_req_q;
  assign rx_ack_o  = rx_ack_q;
  assign ring_en_o = ring_en_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign ret_cnt_o = ret_cnt_q;

endmodule
